// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write/reserve bus of the multi-port register file.
// master drives addresses, write data/enables and Reserve; slave returns ReadData, ReadBusy, BusyCount.
interface regfile_mp_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
);
  logic [NREAD*ADDR_W-1:0] ReadRegister;
  logic [NREAD*WIDTH-1:0]  ReadData;
  logic [NREAD-1:0]        ReadBusy;
  logic [ADDR_W-1:0]       WriteRegister1;
  logic [WIDTH-1:0]        WriteData1;
  logic                    RegWrite1;
  logic [ADDR_W-1:0]       WriteRegister2;
  logic [WIDTH-1:0]        WriteData2;
  logic                    RegWrite2;
  logic                    Reserve;
  logic [ADDR_W-1:0]       ReserveRegister;
  logic [ADDR_W:0]         BusyCount;
  modport master (
    output ReadRegister, WriteRegister1, WriteData1, RegWrite1,
           WriteRegister2, WriteData2, RegWrite2, Reserve, ReserveRegister,
    input  ReadData, ReadBusy, BusyCount
  );
  modport slave (
    input  ReadRegister, WriteRegister1, WriteData1, RegWrite1,
           WriteRegister2, WriteData2, RegWrite2, Reserve, ReserveRegister,
    output ReadData, ReadBusy, BusyCount
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: NREAD-read / 2-write register file with optional bypass, zero register and busy scoreboard.
// Ports: Clk, Reset (async active-high), bus (regfile_mp_if.slave: reads, two writes, Reserve, BusyCount).
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 0,
  parameter int ZERO_REG = 1
) (
  input logic         Clk,
  input logic         Reset,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic ZR = (ZERO_REG != 0);
  localparam logic BP = (BYPASS != 0);
  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              we1, we2, rsv;
  // Effective enables: register 0 is untouchable when hardwired, and nothing
  // is accepted while Reset is held (this also keeps bypass from leaking data).
  assign we1 = bus.RegWrite1 && !Reset && !(ZR && bus.WriteRegister1 == '0);
  assign we2 = bus.RegWrite2 && !Reset && !(ZR && bus.WriteRegister2 == '0);
  assign rsv = bus.Reserve   && !Reset && !(ZR && bus.ReserveRegister == '0);
  // Per-register scoreboard: a write retires the producer, a Reserve in the
  // same cycle marks a new one, so set dominates clear.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if ((we1 && bus.WriteRegister1 == ADDR_W'(r)) || (we2 && bus.WriteRegister2 == ADDR_W'(r)))
        busy_d[r] = 1'b0;
      if (rsv && bus.ReserveRegister == ADDR_W'(r))
        busy_d[r] = 1'b1;
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[r]};
    end
  end
  // Port 2 is applied last so it wins an address collision.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (we1) regs_q[bus.WriteRegister1] <= bus.WriteData1;
      if (we2) regs_q[bus.WriteRegister2] <= bus.WriteData2;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end
  assign bus.BusyCount = cnt_q;
  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = bus.ReadRegister[g*ADDR_W +: ADDR_W];
    assign bus.ReadData[g*WIDTH +: WIDTH] =
      (ZR && ra == '0)                             ? '0             :
      (BP && we2 && bus.WriteRegister2 == ra)      ? bus.WriteData2 :
      (BP && we1 && bus.WriteRegister1 == ra)      ? bus.WriteData1 :
                                                     regs_q[ra];
    assign bus.ReadBusy[g] = busy_q[ra];
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the CPU datapath, generalising the fixed 32x32, 2-read/1-write file. It provides NREAD combinational read ports, two prioritised synchronous write ports, optional write-to-read bypass, an optional hardwired zero register, and a per-register busy scoreboard for the issue stage.

## Interface
- WIDTH, 32: data width in bits.
- ADDR_W, 5: address width; depth is 2**ADDR_W registers.
- NREAD, 2: number of read ports (1..8).
- BYPASS, 0: 1 = a read of a register being written this cycle returns the incoming write data.
- ZERO_REG, 1: 1 = register 0 reads as 0, ignores writes and never goes busy.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all registers and busy bits.
- ReadRegister  in  NREAD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- ReadData  out  NREAD*WIDTH  packed read data; port i at [i*WIDTH +: WIDTH].
- ReadBusy  out  NREAD  busy bit of the register addressed by each read port.
- WriteRegister1  in  ADDR_W  write port 1 address.
- WriteData1  in  WIDTH  write port 1 data.
- RegWrite1  in  1  write port 1 enable.
- WriteRegister2  in  ADDR_W  write port 2 address.
- WriteData2  in  WIDTH  write port 2 data.
- RegWrite2  in  1  write port 2 enable; port 2 has priority over port 1.
- Reserve  in  1  set the busy bit of ReserveRegister at the next edge.
- ReserveRegister  in  ADDR_W  register to reserve.
- BusyCount  out  ADDR_W+1  number of busy registers.

## Operation
- Storage: 2**ADDR_W x WIDTH registers plus 2**ADDR_W busy bits.
- Write: on posedge Clk, if RegWritek, reg[WriteRegisterk] <= WriteDatak. If both ports are enabled with the same address, WriteData2 is stored.
- Read: ReadData[i] = reg[ReadRegister[i]] (combinational). All ports are independent, and any number of ports may address the same register.
- Bypass (BYPASS=1): if RegWrite2 and the addresses match, ReadData[i] = WriteData2. Otherwise, if RegWrite1 and the addresses match, ReadData[i] = WriteData1. Otherwise the stored value is returned. ReadBusy is not bypassed.
- Zero register (ZERO_REG=1): register 0 reads as 0 on every port, including under bypass. Writes to register 0 are discarded. Reserve of register 0 is ignored.
- Scoreboard, evaluated per register at each edge:
  - A register is written when either enabled write port addresses it.
  - Reserve of that register sets its busy bit.
  - A write to it clears its busy bit.
  - If a write and a Reserve hit the same register in the same cycle, busy ends at 1: the write retires the old producer and the Reserve marks a new one.
  - Writes to non-busy registers are legal and leave busy at 0.
- BusyCount is the population count of the busy bits. It is registered and updated in the same edge as the bits. Maximum is 2**ADDR_W (ZERO_REG=0) or 2**ADDR_W-1 (ZERO_REG=1), so the width never wraps.
- ReadBusy[i] = busy[ReadRegister[i]] (combinational from the registered bits).

## Timing
- Reset values: every register 0, every busy bit 0, BusyCount 0. ReadData therefore reads 0 and ReadBusy reads 0 for any address.
- Reset acts immediately on assertion, without waiting for a clock edge, including in the middle of a write or Reserve. While Reset is high, all writes and reserves are ignored.
- Write latency: without bypass, a written value is visible on ReadData after the rising edge, i.e. in the following cycle. With BYPASS=1 it is visible combinationally in the same cycle as the write.
- Busy latency: a Reserve in cycle n makes ReadBusy high from cycle n+1. A write in cycle n makes ReadBusy low from cycle n+1, unless a Reserve hits the same register in cycle n.
- No handshake and no stalls: the block accepts every write and reserve in every cycle.

## Test plan
- Reset and zero register: assert Reset mid-simulation after writing 0xDEADBEEF to register 5 -> register 5 reads 0 immediately and BusyCount=0. Then write 1 to register 0 -> every port reads 0 for register 0 (ZERO_REG=1).
- Write-port priority: in one edge, port 1 writes 10 and port 2 writes 20, both to register 3 -> register 3 reads 20 on all ports. Write 15 to register 2 with RegWrite1=0 -> the value is unchanged.
- Decoder isolation, NREAD=4: clear registers 1..31, write 15 to register 1, sweep all ports over 2..31 -> every port reads 0.
- Port independence: write 5 to register 17 and 8 to register 3. Set port 0 to address 17 and port 1 to address 3 -> 5 and 8. Rewrite 17 with 12 -> port 1 still reads 8.
- Bypass, BYPASS=1: write 0x55 to register 9 with port 0 addressing 9 -> 0x55 is visible before the edge. With BYPASS=0 -> the old value is returned until after the edge.
- Scoreboard: Reserve register 4 -> the next cycle shows ReadBusy=1 and BusyCount=1. In the same cycle, write register 4 and Reserve register 4 -> busy stays 1. Then write register 4 with no Reserve -> busy 0 and BusyCount 0.
